// File: rtl/rle_block_sequencer.sv
// Block sequencer for the 8-lane run-length datapath: feeds rows, compacts enabled
// (run,value) lanes into a pair buffer and emits 8-pair words with a per-block EOB.
module rle_block_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_row_valid,
    output logic        o_row_ready,
    input  logic [63:0] i_row_data,
    output logic [63:0] o_rle_data,
    output logic        o_rle_first,
    output logic        o_rle_adv,
    input  logic [7:0]  i_rle_en,
    input  logic [31:0] i_rle_run,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [95:0] o_out_data,
    output logic [3:0]  o_out_count,
    output logic        o_out_last
);
    // state    | meaning
    // ST_RUN   | accepting rows, emitting full 8-pair words
    // ST_EOB   | block rows done, waiting for room to append the EOB pair
    // ST_FLUSH | draining remaining pairs; final word carries out_last
    localparam int          LANES          = 8;
    localparam int          ROWS_PER_BLOCK = 8;
    localparam int          BUF_PAIRS      = 16;
    localparam logic [11:0] EOB_CODE       = 12'h000;

    typedef enum logic [1:0] {ST_RUN, ST_EOB, ST_FLUSH} state_t;

    state_t      r_state, w_state_next;
    logic [11:0] r_buf [BUF_PAIRS];
    logic [11:0] w_buf_next [BUF_PAIRS];
    logic [4:0]  r_occ, w_occ_next;
    logic [2:0]  r_row_idx, w_row_idx_next;
    logic        r_rst_done;
    logic        w_accept;
    logic        w_drain;
    logic [3:0]  w_drained;
    logic [4:0]  w_base;
    int          w_src;
    int          w_pos;

    always_comb begin
        o_rle_data  = i_row_data;
        o_rle_first = (r_row_idx == 3'd0);
        o_row_ready = r_rst_done && (r_state == ST_RUN) && (r_occ <= 5'(BUF_PAIRS - LANES));
        w_accept    = i_row_valid && o_row_ready;
        o_rle_adv   = w_accept;
        o_out_valid = (r_state == ST_FLUSH) ? (r_occ != 5'd0) : (r_occ >= 5'd8);
        o_out_count = (r_occ >= 5'd8) ? 4'd8 : r_occ[3:0];
        o_out_last  = (r_state == ST_FLUSH) && (r_occ <= 5'd8);
    end

    // Pairs beyond out_count are forced to zero rather than exposing stale buffer slots.
    always_comb begin
        o_out_data = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < o_out_count) o_out_data[95-12*k -: 12] = r_buf[k];
        end
    end

    always_comb begin
        w_drain        = o_out_valid && i_out_ready;
        w_drained      = w_drain ? o_out_count : 4'd0;
        w_base         = r_occ - {1'b0, w_drained};
        w_state_next   = r_state;
        w_row_idx_next = r_row_idx;
        w_occ_next     = w_base;
        w_src          = 0;
        for (int k = 0; k < BUF_PAIRS; k++) begin
            w_src = k + int'(w_drained);
            w_buf_next[k] = (w_src < BUF_PAIRS) ? r_buf[w_src[3:0]] : 12'h000;
        end
        w_pos = int'(w_base);
        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    // New pairs land behind whatever survived this cycle's drain.
                    for (int i = 0; i < LANES; i++) begin
                        if (i_rle_en[7-i]) begin
                            if (w_pos < BUF_PAIRS)
                                w_buf_next[w_pos[3:0]] = {i_rle_run[31-4*i -: 4], i_row_data[63-8*i -: 8]};
                            w_pos = w_pos + 1;
                        end
                    end
                    w_occ_next     = 5'(w_pos);
                    w_row_idx_next = r_row_idx + 3'd1;
                    if (r_row_idx == 3'(ROWS_PER_BLOCK - 1)) begin
                        w_state_next   = ST_EOB;
                        w_row_idx_next = 3'd0;
                    end
                end
            end
            ST_EOB: begin
                if (w_base < 5'(BUF_PAIRS)) begin
                    w_buf_next[w_base[3:0]] = EOB_CODE;
                    w_occ_next              = w_base + 5'd1;
                    w_state_next            = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_drain && o_out_last) w_state_next = ST_RUN;
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_occ      <= 5'd0;
            r_row_idx  <= 3'd0;
            r_rst_done <= 1'b0;
            for (int k = 0; k < BUF_PAIRS; k++) r_buf[k] <= 12'h000;
        end else begin
            r_state    <= w_state_next;
            r_occ      <= w_occ_next;
            r_row_idx  <= w_row_idx_next;
            r_rst_done <= 1'b1;
            for (int k = 0; k < BUF_PAIRS; k++) r_buf[k] <= w_buf_next[k];
        end
    end

endmodule
